// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default oversampling and the baud
// divider math, so the transmitter and receiver derive timing the same way.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // System clocks per oversample tick, truncated (100 MHz / (57600*16) -> 108).
  function automatic int calc_div(input int clk_freq, input int baudrate, input int oversample);
    return clk_freq / (baudrate * oversample);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; clr restarts
// the period so the tick phase can be aligned to an external event.
module baud_tick_gen #(
  parameter int DIV = 108
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start-edge detect, oversampled
// mid-bit sampling, byte output with valid strobe, framing-error strobe and good-byte counter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUDRATE   = 57600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] rx_count
);

  localparam int DIV = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] FULL_LAST = OSW'(OVERSAMPLE - 1);

  logic           r_sync1;
  logic           r_rx_s;
  logic           r_rx_d;
  logic [1:0]     r_state;
  logic [OSW-1:0] r_os_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic [7:0]     r_rx_data;
  logic           r_rx_valid;
  logic           r_frame_err;
  logic [7:0]     r_rx_count;

  logic w_start_edge;
  logic w_clr;
  logic w_tick;

  // Flops reset low, so a line stuck low never produces a start edge until it has been seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_rx_s  <= 1'b0;
      r_rx_d  <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_start_edge = r_rx_d & ~r_rx_s;
  assign w_clr        = (r_state == ST_IDLE) && w_start_edge;

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_count  <= '0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_state  <= ST_START;
            r_os_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_os_cnt == HALF_LAST) begin
              r_os_cnt <= '0;
              if (r_rx_s) begin
                r_state <= ST_IDLE;
              end else begin
                r_state   <= ST_DATA;
                r_bit_idx <= '0;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_os_cnt == FULL_LAST) begin
              r_os_cnt  <= '0;
              r_shift   <= {r_rx_s, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop lets a zero-idle next start bit be caught.
          if (w_tick) begin
            if (r_os_cnt == FULL_LAST) begin
              r_os_cnt <= '0;
              r_state  <= ST_IDLE;
              if (r_rx_s) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_rx_count <= r_rx_count + 8'd1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_count  = r_rx_count;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver pushes expected events per frame,
// a monitor pops and compares them whenever rx_valid or frame_err pulses.
module tb_uart_rx;

  localparam int CLK_FREQ = 2_400_000;
  localparam int BAUDRATE = 100_000;
  localparam int OS       = 8;
  localparam int DIV      = CLK_FREQ / (BAUDRATE * OS);
  localparam int BITC     = CLK_FREQ / BAUDRATE;
  // 2 sync + 1 edge flag, then mid-stop sample point (OS/2 + 9*OS ticks).
  localparam int LAT      = 3 + (OS / 2 + 9 * OS) * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] rx_count;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [7:0] count;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   m_count = 0;
  int   m_data  = 0;
  logic prev_pulse = 1'b0;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUDRATE  (BAUDRATE),
    .OVERSAMPLE(OS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_count (rx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   diff;
    if (!reset && (rx_valid || frame_err)) begin
      check("exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%0h, none expected", rx_valid, frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        check(e.is_err ? "kind_ferr" : "kind_valid", {31'd0, frame_err}, {31'd0, e.is_err});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("rx_count", {24'd0, rx_count}, {24'd0, e.count});
        diff = cyc - e.cyc;
        if (diff < LAT - 1 || diff > LAT + 1) begin
          bad++;
          $display("FAIL latency: got %0d cycles want %0d", diff, LAT);
        end
      end
    end
    prev_pulse = !reset && (rx_valid || frame_err);
  end

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    if (stop_ok) begin
      m_count = (m_count + 1) % 256;
      m_data  = b;
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.data  = m_data[7:0];
    e.count = m_count[7:0];
    e.cyc   = cyc;
    exp_q.push_back(e);
    hold(1'b0, BITC);
    for (int i = 0; i < 8; i++) hold(b[i], BITC);
    hold(stop_ok, BITC);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * 10 * BITC) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  {24'd0, rx_data},  32'd0);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_count"}, {24'd0, rx_count}, 32'd0);
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] rb;
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    hold(1'b1, 30);

    // single byte
    send(8'hA5, 1'b1);
    hold(1'b1, 40);
    drain();
    check("single_data", {24'd0, rx_data}, 32'hA5);
    check("single_count", {24'd0, rx_count}, 32'd1);

    // back-to-back with zero idle
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    hold(1'b1, 10);
    drain();
    check("b2b_data", {24'd0, rx_data}, 32'hFF);
    check("b2b_count", {24'd0, rx_count}, 32'd3);

    // glitch shorter than half a bit
    hold(1'b0, DIV * OS / 2 - 6);
    hold(1'b1, 12 * BITC);
    check("false_start_count", {24'd0, rx_count}, 32'd3);
    send(8'h3C, 1'b1);
    hold(1'b1, 20);
    drain();
    check("after_fs_data", {24'd0, rx_data}, 32'h3C);

    // framing error, line held low as a break, then recovery
    send(8'hE7, 1'b0);
    hold(1'b0, 200);
    hold(1'b1, 3 * BITC);
    drain();
    check("ferr_data_kept", {24'd0, rx_data}, 32'h3C);
    check("ferr_count_kept", {24'd0, rx_count}, 32'd4);
    send(8'h81, 1'b1);
    hold(1'b1, 20);
    drain();
    check("after_ferr_data", {24'd0, rx_data}, 32'h81);

    // reset during data bit 4
    pat = 8'h55;
    hold(1'b0, BITC);
    for (int i = 0; i < 4; i++) hold(pat[i], BITC);
    hold(pat[4], BITC / 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    reset = 1'b0;
    m_count = 0;
    m_data  = 0;
    hold(1'b1, 12 * BITC);
    check("midreset_idle_count", {24'd0, rx_count}, 32'd0);
    send(8'h55, 1'b1);
    hold(1'b1, 20);
    drain();
    check("after_reset_data", {24'd0, rx_data}, 32'h55);

    // long random run from a fresh reset; count must wrap
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_count = 0;
    m_data  = 0;
    hold(1'b1, 10);
    for (int n = 0; n < 260; n++) begin
      int gap;
      rb  = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      send(rb, 1'b1);
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 10);
    drain();
    check("wrap_count", {24'd0, rx_count}, 32'd4);
    check("wrap_model_count", {24'd0, rx_count}, m_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
